// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the block-memory arbiter.
package mem_arbiter_pkg;

    typedef logic [31:0]      addr_t;
    typedef logic [3:0][31:0] block_t;
    typedef logic [2:0]       wr_size_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_GRANT = 2'd3
    } arb_state_e;

    localparam int LANES = 4;

    // Lanes enabled from lane 0 upward; sizes beyond the lane count saturate.
    function automatic logic [LANES-1:0] size_to_lane_en(input wr_size_t size);
        logic [LANES-1:0] lane_en;
        case (size)
            3'd0:    lane_en = 4'b0000;
            3'd1:    lane_en = 4'b0001;
            3'd2:    lane_en = 4'b0011;
            3'd3:    lane_en = 4'b0111;
            default: lane_en = 4'b1111;
        endcase
        return lane_en;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first unmasked request at or after i_ptr, wrapping.
module rr_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic [N-1:0]     i_mask,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0] w_req;

    assign w_req = i_req & ~i_mask;

    always_comb begin
        logic [IDX_W-1:0] w_j;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_j      = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IDX_W'((int'(i_ptr) + k) % N);
            if (!o_any && w_req[w_j]) begin
                o_any         = 1'b1;
                o_idx         = w_j;
                o_onehot[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serving block reads/writes from NPROC processors onto one SRAM port.
//   state       | meaning
//   ST_IDLE     | pick next requester (last-served one masked for one cycle after a grant)
//   ST_ISSUE    | drive SRAM access; writes are granted here
//   ST_RD_WAIT  | SRAM read data returns and is captured
//   ST_RD_GRANT | read grant pulse with o_rdata valid
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NPROC  = 4,
    parameter int ADDR_W = $bits(addr_t)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NPROC-1:0]              i_req_rd,
    input  logic [NPROC-1:0]              i_req_wr,
    input  logic [NPROC-1:0][ADDR_W-1:0]  i_addr,
    input  logic [NPROC-1:0][2:0]         i_wr_size,
    input  logic [NPROC-1:0][127:0]       i_wdata,
    output logic [NPROC-1:0]              o_grant_rd,
    output logic [NPROC-1:0]              o_grant_wr,
    output logic [127:0]                  o_rdata,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [3:0]                    o_mem_lane_en,
    output logic [127:0]                  o_mem_wdata,
    input  logic [127:0]                  i_mem_rdata
);

    localparam int IDX_W = (NPROC > 1) ? $clog2(NPROC) : 1;

    arb_state_e         r_state;
    arb_state_e         w_state_next;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_win_idx;
    logic [NPROC-1:0]   r_win_oh;
    logic [NPROC-1:0]   r_mask;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    wr_size_t           r_size;
    block_t             r_wdata;
    block_t             r_rdata;

    logic [NPROC-1:0]   w_req;
    logic [NPROC-1:0]   w_win_oh;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any;
    logic               w_grant;

    assign w_req   = i_req_rd | i_req_wr;
    assign w_grant = ((r_state == ST_ISSUE) && r_we) || (r_state == ST_RD_GRANT);
    assign o_rdata = r_rdata;

    rr_pick #(.N(NPROC)) u_pick (
        .i_req    (w_req),
        .i_ptr    (r_rr_ptr),
        .i_mask   (r_mask),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_any) w_state_next = ST_ISSUE;
            ST_ISSUE:    w_state_next = r_we ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT:  w_state_next = ST_RD_GRANT;
            ST_RD_GRANT: w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mem_en      = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_lane_en = '0;
        o_mem_wdata   = '0;
        o_grant_wr    = '0;
        o_grant_rd    = '0;
        case (r_state)
            ST_ISSUE: begin
                o_mem_en   = 1'b1;
                o_mem_we   = r_we;
                o_mem_addr = r_addr;
                if (r_we) begin
                    o_mem_lane_en = size_to_lane_en(r_size);
                    o_mem_wdata   = r_wdata;
                    o_grant_wr    = r_win_oh;
                end
            end
            ST_RD_GRANT: o_grant_rd = r_win_oh;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr  <= '0;
            r_win_idx <= '0;
            r_win_oh  <= '0;
            r_mask    <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_size    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            // The mask only covers the single IDLE cycle that follows a grant.
            r_mask <= w_grant ? r_win_oh : '0;
            if (w_grant) begin
                r_rr_ptr <= (r_win_idx == IDX_W'(NPROC - 1)) ? '0 : r_win_idx + 1'b1;
            end
            if ((r_state == ST_IDLE) && w_any) begin
                r_win_idx <= w_win_idx;
                r_win_oh  <= w_win_oh;
                r_addr    <= i_addr[w_win_idx];
                r_we      <= i_req_wr[w_win_idx];
                r_size    <= i_wr_size[w_win_idx];
                r_wdata   <= i_wdata[w_win_idx];
            end
            if (r_state == ST_RD_WAIT) begin
                r_rdata <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level arbitration model feeding a scoreboard queue.
module tb_mem_arbiter;

    localparam int NP = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0]          req_rd, req_wr;
    logic [NP-1:0][31:0]    addr;
    logic [NP-1:0][2:0]     wsize;
    logic [NP-1:0][127:0]   wdata;
    logic [NP-1:0]          o_grant_rd, o_grant_wr;
    logic [127:0]           o_rdata;
    logic                   o_mem_en, o_mem_we;
    logic [31:0]            o_mem_addr;
    logic [3:0]             o_mem_lane_en;
    logic [127:0]           o_mem_wdata;
    logic [127:0]           mem_rdata;

    typedef struct {
        int           proc;
        bit           wr;
        int           issue;
        int           grant;
        logic [31:0]  addr;
        logic [3:0]   lane;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    exp_t       expq[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;
    bit         run = 1'b0;
    bit [NP-1:0] act = '0;
    bit [NP-1:0] late = '0;
    int         rdwait_cyc = -1;

    mem_arbiter #(.NPROC(NP), .ADDR_W(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_rd      (req_rd),
        .i_req_wr      (req_wr),
        .i_addr        (addr),
        .i_wr_size     (wsize),
        .i_wdata       (wdata),
        .o_grant_rd    (o_grant_rd),
        .o_grant_wr    (o_grant_wr),
        .o_rdata       (o_rdata),
        .o_mem_en      (o_mem_en),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_lane_en (o_mem_lane_en),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] sram_val(input logic [31:0] a);
        if (a == 32'h40) return 128'h11111111_22222222_33333333_44444444;
        return {a ^ 32'hA5A5_0000, ~a, a * 32'd3, a + 32'd7};
    endfunction

    function automatic logic [3:0] exp_lane(input logic [2:0] s);
        if (s == 3'd0) return 4'h0;
        if (s >= 3'd4) return 4'hF;
        return 4'((1 << s) - 1);
    endfunction

    task automatic check(input string name, input logic [191:0] act_v, input logic [191:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act_v, exp_v);
        end
    endtask

    task automatic new_req(input int i);
        int r;
        r = $urandom_range(3);
        act[i]    = 1'b1;
        req_rd[i] = (r != 2);
        req_wr[i] = (r >= 2);
        addr[i]   = ($urandom_range(3) == 0) ? 32'h40 : $urandom;
        wsize[i]  = 3'($urandom_range(7));
        wdata[i]  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_grant(output int p, output int at);
        p  = -1;
        at = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk); #2;
            if ((o_grant_rd | o_grant_wr) != '0) begin
                for (int i = 0; i < NP; i++) begin
                    if (o_grant_rd[i] | o_grant_wr[i]) p = i;
                end
                at = cyc;
                return;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SRAM: read data valid the cycle after a read strobe, junk otherwise.
    initial begin
        logic        en_q;
        logic [31:0] a_q;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            en_q = (o_mem_en === 1'b1) && (o_mem_we === 1'b0);
            a_q  = o_mem_addr;
            @(posedge clk); #1;
            mem_rdata = en_q ? sram_val(a_q) : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Processors: hold until granted, sometimes drop one cycle late.
    initial begin
        logic [NP-1:0] gseen;
        forever begin
            @(negedge clk);
            gseen = o_grant_rd | o_grant_wr;
            @(posedge clk); #1;
            for (int i = 0; i < NP; i++) begin
                if (late[i]) begin
                    late[i]   = 1'b0;
                    req_rd[i] = 1'b0;
                    req_wr[i] = 1'b0;
                end else if (act[i] && (gseen[i] === 1'b1)) begin
                    act[i] = 1'b0;
                    if ($urandom_range(2) == 0) begin
                        late[i] = 1'b1;
                    end else begin
                        req_rd[i] = 1'b0;
                        req_wr[i] = 1'b0;
                    end
                end else if (!act[i] && run && ($urandom_range(3) == 0)) begin
                    new_req(i);
                end
            end
        end
    end

    // Reference model: whenever the arbiter is free, serve the first requester at/after ptr.
    initial begin
        int            ptr, free_at, mask_at, mask_p, j;
        logic [NP-1:0] req;
        exp_t          e;
        ptr = 0; free_at = 0; mask_at = -1; mask_p = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                expq.delete();
                ptr        = 0;
                free_at    = cyc + 1;
                mask_at    = -1;
                rdwait_cyc = -1;
            end else if (cyc >= free_at) begin
                req = req_rd | req_wr;
                if (cyc == mask_at) req[mask_p] = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    j = (ptr + k) % NP;
                    if (req[j]) begin
                        e.proc  = j;
                        e.wr    = req_wr[j];
                        e.issue = cyc + 1;
                        e.grant = e.wr ? cyc + 1 : cyc + 3;
                        e.addr  = addr[j];
                        e.lane  = e.wr ? exp_lane(wsize[j]) : 4'h0;
                        e.wdata = wdata[j];
                        e.rdata = sram_val(addr[j]);
                        expq.push_back(e);
                        free_at = e.wr ? cyc + 2 : cyc + 4;
                        ptr     = (j + 1) % NP;
                        mask_at = free_at;
                        mask_p  = j;
                        if (!e.wr) rdwait_cyc = cyc + 2;
                        break;
                    end
                end
            end
        end
    end

    // Monitor: compares SRAM strobes and grants against the expected queue.
    initial begin
        exp_t          e;
        logic [NP-1:0] er, ew;
        forever begin
            @(negedge clk); #1;
            if (mon_en) begin
                if (expq.size() > 0 && expq[0].issue == cyc) begin
                    check("mem_en", o_mem_en, 1);
                    check("mem_we", o_mem_we, expq[0].wr);
                    check("mem_addr", o_mem_addr, expq[0].addr);
                    check("mem_lane_en", o_mem_lane_en, expq[0].lane);
                    if (expq[0].wr) check("mem_wdata", o_mem_wdata, expq[0].wdata);
                end else begin
                    check("mem_idle", {o_mem_en, o_mem_we, o_mem_lane_en, o_mem_addr, o_mem_wdata}, '0);
                end
                if (expq.size() > 0 && expq[0].grant <= cyc) begin
                    e  = expq.pop_front();
                    er = '0;
                    ew = '0;
                    if (e.wr) ew[e.proc] = 1'b1;
                    else      er[e.proc] = 1'b1;
                    check("grant", {o_grant_rd, o_grant_wr}, {er, ew});
                    if (!e.wr) check("rdata", o_rdata, e.rdata);
                end else begin
                    check("no_grant", {o_grant_rd, o_grant_wr}, '0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, at, prev;
        bit found, busy;
        rst    = 1'b1;
        req_rd = '1;
        req_wr = '0;
        act    = '1;
        for (int i = 0; i < NP; i++) begin
            addr[i]  = 32'h40 * (i + 1);
            wsize[i] = '0;
            wdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ctrl", {o_grant_rd, o_grant_wr, o_mem_en, o_mem_we, o_mem_lane_en, o_mem_addr}, '0);
        check("rst_rdata", o_rdata, '0);
        check("rst_wdata", o_mem_wdata, '0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        prev = 0;
        for (int k = 0; k < NP; k++) begin
            wait_grant(p, at);
            check("rot_order", p, k);
            if (k > 0) check("rot_spacing", at - prev, 4);
            prev = at;
        end

        run = 1'b1;
        repeat (3000) @(posedge clk);

        found = 1'b0;
        for (int t = 0; t < 500 && !found; t++) begin
            @(posedge clk); #1;
            if (rdwait_cyc == cyc) found = 1'b1;
        end
        check("find_rd_wait", found, 1);
        if (found) begin
            rst = 1'b1;
            @(negedge clk); #2;
            check("rst_mid_grant_rd", o_grant_rd, '0);
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk); #2;
            check("rst_mid_no_grant", o_grant_rd, '0);
            check("rst_mid_rdata", o_rdata, '0);
        end

        repeat (1000) @(posedge clk);
        run  = 1'b0;
        busy = 1'b1;
        for (int t = 0; t < 300 && busy; t++) begin
            @(posedge clk); #2;
            busy = (act != '0) || (late != '0) || (expq.size() != 0);
        end
        check("drain", busy, 0);
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
